// File: rtl/dump_pkg.sv
// Purpose: shared constants and FSM state type for the post-halt result dumper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dump_pkg;

    // Frame marker sent ahead of the data bytes; it is not part of the checksum.
    localparam logic [7:0] DUMP_HEADER = 8'hA5;

    // 100 MHz core clock / 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        MEM_RD,
        MEM_HI,
        MEM_LO,
        REG_HI,
        REG_LO,
        CSUM,
        DRAIN
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// Purpose: UART 8N1 byte serializer (start bit, D0..D7 LSB first, stop bit).
// Latency: the start bit appears on tx the cycle after valid & ready.
// Backpressure: ready is high only while idle and drops the cycle after a byte is taken.
// Ports: CLK/rst (sync, active-high), data/valid/ready byte handshake, tx serial line (idle high).
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [3:0]    bit_cnt;    // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [BW-1:0] baud_cnt;
    logic [8:0]    shreg;      // remaining data bits with the stop bit parked on top

    assign ready = ~active;

    always_ff @(posedge CLK) begin
        if (rst) begin
            active   <= 1'b0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            shreg    <= '1;
            tx       <= 1'b1;
        end else if (!active) begin
            if (valid) begin
                active   <= 1'b1;
                tx       <= 1'b0;
                shreg    <= {1'b1, data};
                bit_cnt  <= 4'd0;
                baud_cnt <= '0;
            end
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                // Stop bit complete; tx is already high and stays there.
                active <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/result_dumper.sv
// Purpose: on a halt rising edge, stream header, all memory words, all registers and an XOR checksum over UART.
// Latency: busy rises the cycle after the halt edge; the header start bit follows one cycle later.
// Backpressure: the FSM advances only when the serializer accepts a byte; halt edges while busy are ignored.
// Ports: CLK/rst (sync, active-high), halt trigger, mem_addr/mem_rdata (1-cycle registered read),
//        reg_addr/reg_rdata (combinational read), tx UART line, busy level, done one-cycle pulse.
module result_dumper
    import dump_pkg::*;
#(
    parameter int MEM_WORDS    = 16,
    parameter int REG_WORDS    = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        halt,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  reg_addr,
    input  logic [15:0] reg_rdata,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] MEM_LAST = 16'(MEM_WORDS - 1);
    localparam logic [2:0]  REG_LAST = 3'(REG_WORDS - 1);

    state_t      state_q, state_d;
    logic        halt_q;
    logic [15:0] addr_q;
    logic [2:0]  ridx_q;
    logic [15:0] word_q;
    logic [7:0]  csum_q;
    logic        rd_wait_q;   // second cycle of MEM_RD: mem_rdata now reflects addr_q
    logic        done_q;
    logic        done_d;

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        accept;

    assign accept   = tx_valid & tx_ready;
    assign mem_addr = addr_q;
    assign reg_addr = ridx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt & ~halt_q) state_d = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = DUMP_HEADER;
                if (tx_ready) state_d = MEM_RD;
            end
            MEM_RD: begin
                if (rd_wait_q) state_d = MEM_HI;
            end
            MEM_HI: begin
                tx_valid = 1'b1;
                tx_data  = word_q[15:8];
                if (tx_ready) state_d = MEM_LO;
            end
            MEM_LO: begin
                tx_valid = 1'b1;
                tx_data  = word_q[7:0];
                if (tx_ready) state_d = (addr_q == MEM_LAST) ? REG_HI : MEM_RD;
            end
            REG_HI: begin
                // Register file reads combinationally, so the high byte goes out directly.
                tx_valid = 1'b1;
                tx_data  = reg_rdata[15:8];
                if (tx_ready) state_d = REG_LO;
            end
            REG_LO: begin
                tx_valid = 1'b1;
                tx_data  = word_q[7:0];
                if (tx_ready) state_d = (ridx_q == REG_LAST) ? CSUM : REG_HI;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) state_d = DRAIN;
            end
            DRAIN: begin
                // ready returns only once the checksum's stop bit has finished.
                if (tx_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            addr_q    <= 16'd0;
            ridx_q    <= 3'd0;
            word_q    <= 16'd0;
            csum_q    <= 8'd0;
            rd_wait_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (halt & ~halt_q) begin
                        addr_q    <= 16'd0;
                        ridx_q    <= 3'd0;
                        csum_q    <= 8'd0;
                        rd_wait_q <= 1'b0;
                    end
                end
                MEM_RD: begin
                    rd_wait_q <= ~rd_wait_q;
                    if (rd_wait_q) word_q <= mem_rdata;
                end
                MEM_HI: begin
                    if (accept) csum_q <= csum_q ^ tx_data;
                end
                MEM_LO: begin
                    if (accept) begin
                        csum_q <= csum_q ^ tx_data;
                        // Compare before increment so the address never passes the last word.
                        if (addr_q != MEM_LAST) addr_q <= addr_q + 16'd1;
                    end
                end
                REG_HI: begin
                    if (accept) begin
                        csum_q <= csum_q ^ tx_data;
                        word_q <= reg_rdata;
                    end
                end
                REG_LO: begin
                    if (accept) begin
                        csum_q <= csum_q ^ tx_data;
                        if (ridx_q != REG_LAST) ridx_q <= ridx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .CLK  (CLK),
        .rst  (rst),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_result_dumper.sv
// Purpose: directed/random checks of result_dumper through a UART line decoder and a frame model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_result_dumper;

    localparam int CPB    = 4;
    localparam int NMEM   = 16;
    localparam int NREG   = 8;
    localparam int NBYTES = 2 + 2 * (NMEM + NREG);

    logic        CLK = 1'b0;
    logic        rst;
    logic        halt;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [2:0]  reg_addr;
    logic [15:0] reg_rdata;
    logic        tx;
    logic        busy;
    logic        done;

    logic [15:0] mem_m [NMEM];
    logic [15:0] reg_m [NREG];

    int nasrt = 0;
    int nfail = 0;
    int cyc   = 0;

    // Observers
    int         done_cnt      = 0;
    int         done_busy_err = 0;
    int         max_addr      = 0;
    int         rise_cyc      = 0;
    logic       busy_prev     = 1'b0;
    logic [7:0] rx_q [$];
    int         bit_err       = 0;
    int         max_gap       = 0;
    int         hdr_max       = 0;
    int         last_end      = 0;
    logic       have_prev     = 1'b0;

    result_dumper #(
        .MEM_WORDS   (NMEM),
        .REG_WORDS   (NREG),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .halt     (halt),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .reg_addr (reg_addr),
        .reg_rdata(reg_rdata),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) mem_rdata <= mem_m[mem_addr[3:0]];
    assign reg_rdata = reg_m[reg_addr];

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(negedge CLK);
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0 || busy_prev !== 1'b1) done_busy_err++;
        end
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        if (busy === 1'b1 && busy_prev !== 1'b1) rise_cyc = cyc;
        busy_prev = busy;
    end

    // UART decoder: every bit is sampled on all CPB cycles and must be constant.
    initial begin
        logic [7:0] b;
        logic       bv;
        logic       ab;
        int         sc;
        int         errs;
        forever begin
            @(negedge CLK);
            if (busy !== 1'b1) have_prev = 1'b0;
            if (tx === 1'b0 && rst === 1'b0) begin
                sc   = cyc;
                ab   = 1'b0;
                b    = 8'h00;
                bv   = 1'b0;
                errs = 0;
                if (!have_prev) begin
                    if (sc - rise_cyc > hdr_max) hdr_max = sc - rise_cyc;
                end else if (sc - last_end - 1 > max_gap) begin
                    max_gap = sc - last_end - 1;
                end
                for (int bi = 0; bi < 10; bi++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (bi != 0 || c != 0) @(negedge CLK);
                        if (rst !== 1'b0) ab = 1'b1;
                        if (c == 0) bv = tx;
                        else if (tx !== bv) errs++;
                    end
                    if (bi == 0 && bv !== 1'b0) errs++;
                    if (bi == 9 && bv !== 1'b1) errs++;
                    if (bi >= 1 && bi <= 8) b[bi-1] = bv;
                end
                if (!ab) begin
                    bit_err  = bit_err + errs;
                    rx_q.push_back(b);
                    last_end  = cyc;
                    have_prev = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nasrt++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
        repeat (20) @(negedge CLK);
        chk({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic run_dump(input string tag, output int base);
        int d0;
        base = rx_q.size();
        d0   = done_cnt;
        halt = 1'b1;
        repeat (3) @(negedge CLK);
        halt = 1'b0;
        wait_done(tag, d0);
    endtask

    // Expected frame computed directly from the memory/register contents.
    task automatic check_frame(input string tag, input int base);
        logic [7:0] e [$];
        logic [7:0] cs;
        cs = 8'h00;
        e.push_back(8'hA5);
        for (int i = 0; i < NMEM; i++) begin
            e.push_back(mem_m[i][15:8]);
            e.push_back(mem_m[i][7:0]);
            cs = cs ^ mem_m[i][15:8] ^ mem_m[i][7:0];
        end
        for (int i = 0; i < NREG; i++) begin
            e.push_back(reg_m[i][15:8]);
            e.push_back(reg_m[i][7:0]);
            cs = cs ^ reg_m[i][15:8] ^ reg_m[i][7:0];
        end
        e.push_back(cs);
        chk({tag, "_len"}, 32'(rx_q.size() - base), 32'(NBYTES));
        for (int i = 0; i < NBYTES; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base+i]), 32'(e[i]));
        end
        chk({tag, "_bit_timing"}, 32'(bit_err), 32'd0);
        chk({tag, "_gap_le3"}, 32'(max_gap <= 3), 32'd1);
        chk({tag, "_hdr_start_le2"}, 32'(hdr_max <= 2), 32'd1);
        chk({tag, "_done_busy"}, 32'(done_busy_err), 32'd0);
    endtask

    initial begin
        int base;
        int base2;
        int d0;
        int k;

        rst  = 1'b1;
        halt = 1'b0;
        for (int i = 0; i < NMEM; i++) mem_m[i] = 16'h0000;
        for (int i = 0; i < NREG; i++) reg_m[i] = 16'h0000;
        repeat (3) @(negedge CLK);

        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_reg_addr", 32'(reg_addr), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge CLK);
        chk("idle_no_frame", 32'(rx_q.size()), 32'd0);

        // All-zero machine state
        run_dump("zero", base);
        check_frame("zero", base);
        if (rx_q.size() >= base + NBYTES)
            chk("zero_csum", 32'(rx_q[base+NBYTES-1]), 32'h00);

        // Known register results
        reg_m[1] = 16'h00F5;
        reg_m[2] = 16'h74C2;
        run_dump("known", base);
        check_frame("known", base);
        if (rx_q.size() >= base + NBYTES) begin
            chk("known_reg1_lo", 32'(rx_q[base+36]), 32'hF5);
            chk("known_reg2_hi", 32'(rx_q[base+37]), 32'h74);
            chk("known_csum", 32'(rx_q[base+NBYTES-1]), 32'h43);
        end

        // Memory ordering
        for (int i = 0; i < NMEM; i++) mem_m[i] = 16'(i * 257);
        for (int i = 0; i < NREG; i++) reg_m[i] = 16'($urandom);
        run_dump("memord", base);
        check_frame("memord", base);
        chk("memord_max_addr", 32'(max_addr <= NMEM - 1), 32'd1);

        // Fully random contents
        for (int i = 0; i < NMEM; i++) mem_m[i] = 16'($urandom);
        for (int i = 0; i < NREG; i++) reg_m[i] = 16'($urandom);
        run_dump("rand", base);
        check_frame("rand", base);

        // Halt toggled while busy, then left high after done
        base = rx_q.size();
        d0   = done_cnt;
        halt = 1'b1;
        repeat (30) @(negedge CLK);
        halt = 1'b0;
        repeat (30) @(negedge CLK);
        halt = 1'b1;
        repeat (30) @(negedge CLK);
        halt = 1'b0;
        repeat (5) @(negedge CLK);
        halt = 1'b1;
        wait_done("retrig", d0);
        repeat (600) @(negedge CLK);
        chk("retrig_single_frame", 32'(rx_q.size() - base), 32'(NBYTES));
        chk("retrig_held_no_done", 32'(done_cnt), 32'(d0 + 1));
        chk("retrig_held_idle", 32'(busy), 32'd0);
        check_frame("retrig", base);

        // Fall then rise gives a second identical frame
        halt = 1'b0;
        repeat (3) @(negedge CLK);
        run_dump("rearm", base2);
        check_frame("rearm", base2);

        // Reset in the middle of byte 10
        for (int i = 0; i < NMEM; i++) mem_m[i] = 16'($urandom);
        base = rx_q.size();
        d0   = done_cnt;
        halt = 1'b1;
        repeat (3) @(negedge CLK);
        halt = 1'b0;
        k = 0;
        while (rx_q.size() < base + 10 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk("rstmid_reached_byte10", 32'(rx_q.size() >= base + 10), 32'd1);
        repeat (10) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        chk("rstmid_tx", 32'(tx), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        repeat (60) @(negedge CLK);
        chk("rstmid_partial_dropped", 32'(rx_q.size() - base), 32'd10);
        chk("rstmid_no_done", 32'(done_cnt), 32'(d0));
        run_dump("after_rst", base);
        check_frame("after_rst", base);

        // Halt already high when reset releases starts a dump
        for (int i = 0; i < NREG; i++) reg_m[i] = 16'($urandom);
        rst  = 1'b1;
        halt = 1'b1;
        repeat (3) @(negedge CLK);
        base = rx_q.size();
        d0   = done_cnt;
        rst  = 1'b0;
        wait_done("rst_release", d0);
        halt = 1'b0;
        check_frame("rst_release", base);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule

// File: doc/result_dumper.md
# result_dumper

Post-halt result readout for the 16-bit CPU. When the CPU halts, the block reads every data-memory word and every general register, then streams them off-chip as one framed, checksummed UART 8N1 byte stream. It carries the CPU's results off the board, and a bench decodes the stream to check final machine state. It sits beside the CPU top and uses its own read ports into the memory and decode stages.

## Interface
- MEM_WORDS, 16, number of data-memory words dumped, starting at address 0
- REG_WORDS, 8, number of registers dumped, starting at index 0
- CLKS_PER_BIT, 868, CLK cycles per UART bit; must be ≥ 2
- CLK  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- halt  in  1  CPU halt level; a rising edge starts a dump
- mem_addr  out  16  data-memory read address
- mem_rdata  in  16  memory read data; registered, valid exactly 1 cycle after mem_addr
- reg_addr  out  3  register-file read index
- reg_rdata  in  16  register read data; combinational from reg_addr
- tx  out  1  UART line; idle high
- busy  out  1  high from the trigger cycle until the final stop bit completes
- done  out  1  one-cycle pulse in the cycle after the final stop bit

## Operation
- Frame, in order, 2+2·(MEM_WORDS+REG_WORDS) bytes (50 at defaults):
  - header 0xA5
  - mem[0..MEM_WORDS-1], each word MSB byte first
  - reg[0..REG_WORDS-1], each word MSB byte first
  - checksum byte = XOR of all data bytes (header excluded)
- FSM states: IDLE, HDR, MEM_RD, MEM_HI, MEM_LO, REG_HI, REG_LO, CSUM, DRAIN.
  - IDLE→HDR on halt rising edge (halt & ~halt_q).
  - HDR sends 0xA5, then MEM_RD.
  - MEM_RD drives the address and waits 1 cycle, then latches mem_rdata into a 16-bit word register.
  - MEM_HI→MEM_LO; after MEM_LO, increment the address and go to MEM_RD, or to REG_HI once the address reaches MEM_WORDS-1.
  - REG_HI→REG_LO. Latch reg_rdata in REG_HI. After REG_LO, advance the index until REG_WORDS-1 is sent.
  - CSUM sends the checksum, then DRAIN waits for the stop bit, then IDLE with a done pulse.
- Byte handshake to the serializer is valid/ready. A byte is taken on valid & ready, and ready drops the next cycle. The FSM advances only on acceptance.
- Checksum register is 8 bits, cleared on trigger, XOR-updated on acceptance of each data byte.
- Counters: address wraps nowhere. The terminal compare happens before increment, so mem_addr never exceeds MEM_WORDS-1.
- Boundary rules:
  - halt rising while busy: ignored.
  - halt held high after done: no retrigger until it falls and rises again.
  - halt_q resets to 0, so halt high at reset release triggers a dump.
  - rst mid-dump: next edge forces tx=1, busy=0, done=0, IDLE. The partial byte is abandoned.

## Timing
- Reset values: tx=1, busy=0, done=0, mem_addr=0, reg_addr=0.
- busy rises in the cycle after the halt edge is sampled.
- Start bit of the header begins ≤ 2 cycles after busy rises.
- Each bit lasts exactly CLKS_PER_BIT cycles. Bit order: start(0), D0..D7 LSB first, stop(1).
- Inter-byte idle gap is ≤ 3 cycles (memory read latency included). Total dump time is ≤ 50·(10·CLKS_PER_BIT+3)+4 cycles.
- done pulses exactly once per dump. busy falls in the same cycle as done.

## Structure
- Shared package dump_pkg holds:
  - DUMP_HEADER = 8'hA5
  - default CLKS_PER_BIT
  - the state enum typedef
- Sub-module uart_tx, the byte serializer:
  - ports: CLK, rst, data[7:0], valid, ready, tx
  - internal: bit counter, baud counter, shift register
- Top-level result_dumper holds the FSM, the counters, the word register and the checksum.

## Test plan
All scenarios use CLKS_PER_BIT=4 with a UART monitor decoding the tx line.

- **All-zero state:** memory and registers all zero, pulse halt. Expect 50 bytes: A5, 48×00, checksum 00, then a single done pulse.
- **Known results:** reg[1]=245 (00F5), reg[2]=29890 (74C2), all else zero. Expect reg bytes 00 00 00 F5 74 C2 …, checksum 0x43.
- **Memory ordering:** mem[i]=16'h0100·i+i. Expect bytes 00 00 01 01 02 02 … 0F 0F in order. Also check mem_addr never exceeds 15.
- **Retrigger rules:**
  - toggle halt during busy: expect no second frame.
  - hold halt high after done: expect no new frame.
  - fall then rise: expect a second identical frame.
- **Reset mid-frame:** assert rst during byte 10. Expect tx=1 and busy=0 on the next edge. A later halt edge yields a complete, correct frame.
- **Bit timing:** measure every bit width as exactly 4 cycles, stop bit high, inter-byte gap ≤ 3 cycles.
